// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared types for the data-memory arbiter slice:
//   - XLEN          : address width of the data-memory port
//   - BUS_COMMAND   : memory bus command encoding (NONE/LOAD/STORE)
//   - MEM_SIZE      : access size encoding (BYTE/HALF/WORD/DOUBLE)
//   - DMEM_ARB_STATE: arbiter FSM states
//   - rr_next()     : round-robin pointer advance helper
package dmem_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'h0,
        ISSUE = 2'h1,
        WAIT  = 2'h2,
        RESP  = 2'h3
    } DMEM_ARB_STATE;

    // Next round-robin start position after 'owner' has been served.
    function automatic int unsigned rr_next(input int unsigned owner,
                                            input int unsigned n);
        return (owner + 1) % n;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// dmem_arbiter_rr_picker
//   Combinational round-robin select: returns the first set request bit
//   found searching upward from i_ptr with wrap-around.
//   Ports:
//     i_req    [N_REQ]  request vector
//     i_ptr    [PTR_W]  search start index
//     o_onehot [N_REQ]  one-hot winner (all zero when no request)
//     o_idx    [PTR_W]  binary index of the winner
//     o_any             at least one request present
module dmem_arbiter_rr_picker #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    logic w_found;

    assign o_any = |i_req;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            logic [PTR_W-1:0] idx;
            idx = PTR_W'((32'(i_ptr) + k) % N_REQ);
            if (!w_found && i_req[idx]) begin
                w_found       = 1'b1;
                o_onehot[idx] = 1'b1;
                o_idx         = idx;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-memory port between N_REQ memory FUs (index 0 is
//   the load FU). Round-robin grant, one bus transaction in flight. A command
//   is accepted when Dmem2proc_response is non-zero; loads then wait for the
//   returned block carrying that tag. The raw 64-bit block goes back to the
//   owner; extension is left to the FU.
//
//   Optional feature (macro DMEM_ARB_TIMEOUT_EN): WAIT watchdog. After
//   TIMEOUT cycles without a matching tag the owner is acked with rsp_err=1
//   and rsp_data=0. Without the macro WAIT is unbounded and rsp_err is 0.
//
//   Ports:
//     clock, reset               clock, asynchronous active-low reset
//     req_valid/cmd/addr/data/size  per-FU request, held until req_ack
//     req_grant                  one-hot owner, ISSUE through RESP
//     req_ack                    one-cycle completion pulse to the owner
//     rsp_data, rsp_err          load block / timeout flag, valid with ack
//     proc2Dmem_*                registered memory command and payload
//     Dmem2proc_response/data/tag   memory accept tag, load data, data tag
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [2*N_REQ-1:0]    req_cmd,
    input  logic [XLEN*N_REQ-1:0] req_addr,
    input  logic [64*N_REQ-1:0]   req_data,
    input  logic [2*N_REQ-1:0]    req_size,
    output logic [N_REQ-1:0]      req_grant,
    output logic [N_REQ-1:0]      req_ack,
    output logic [63:0]           rsp_data,
    output logic                  rsp_err,
    output logic [1:0]            proc2Dmem_command,
    output logic [XLEN-1:0]       proc2Dmem_addr,
    output logic [63:0]           proc2Dmem_data,
    output logic [1:0]            proc2Dmem_size,
    input  logic [3:0]            Dmem2proc_response,
    input  logic [63:0]           Dmem2proc_data,
    input  logic [3:0]            Dmem2proc_tag
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    DMEM_ARB_STATE    r_state;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_owner;
    BUS_COMMAND       r_cmd;
    BUS_COMMAND       r_mem_cmd;
    logic [XLEN-1:0]  r_addr;
    logic [63:0]      r_data;
    MEM_SIZE          r_size;
    logic [3:0]       r_tag;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] r_ack;
    logic [63:0]      r_rsp_data;

    logic [N_REQ-1:0] w_pick_onehot;
    logic [PTR_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_tag_hit;

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_rsp_err;
`else
    logic             w_unused_timeout;
    assign w_unused_timeout = ^32'(TIMEOUT);
`endif

    dmem_arbiter_rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Tag 0 means "no data returning", so it never matches.
    assign w_tag_hit = (Dmem2proc_tag != 4'h0) && (Dmem2proc_tag == r_tag);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_cmd      <= BUS_NONE;
            r_mem_cmd  <= BUS_NONE;
            r_addr     <= '0;
            r_data     <= '0;
            r_size     <= BYTE;
            r_tag      <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_rsp_data <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_rsp_err  <= 1'b0;
`endif
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_owner   <= w_pick_idx;
                        r_grant   <= w_pick_onehot;
                        r_cmd     <= BUS_COMMAND'(req_cmd[2*w_pick_idx +: 2]);
                        r_mem_cmd <= BUS_COMMAND'(req_cmd[2*w_pick_idx +: 2]);
                        r_addr    <= req_addr[XLEN*w_pick_idx +: XLEN];
                        r_data    <= req_data[64*w_pick_idx +: 64];
                        r_size    <= MEM_SIZE'(req_size[2*w_pick_idx +: 2]);
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (Dmem2proc_response != 4'h0) begin
                        r_mem_cmd <= BUS_NONE;
                        if (r_cmd == BUS_LOAD) begin
                            r_tag   <= Dmem2proc_response;
                            r_state <= WAIT;
`ifdef DMEM_ARB_TIMEOUT_EN
                            r_wait_cnt <= '0;
`endif
                        end else begin
                            r_ack   <= r_grant;
                            r_state <= RESP;
`ifdef DMEM_ARB_TIMEOUT_EN
                            r_rsp_err <= 1'b0;
`endif
                        end
                    end
                end
                WAIT: begin
                    if (w_tag_hit) begin
                        r_rsp_data <= Dmem2proc_data;
                        r_ack      <= r_grant;
                        r_state    <= RESP;
`ifdef DMEM_ARB_TIMEOUT_EN
                        r_rsp_err  <= 1'b0;
                    end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_ack      <= r_grant;
                        r_state    <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    r_grant  <= '0;
                    r_rr_ptr <= PTR_W'(rr_next(32'(r_owner), N_REQ));
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_grant         = r_grant;
    assign req_ack           = r_ack;
    assign rsp_data          = r_rsp_data;
    assign proc2Dmem_command = r_mem_cmd;
    assign proc2Dmem_addr    = r_addr;
    assign proc2Dmem_data    = r_data;
    assign proc2Dmem_size    = r_size;
`ifdef DMEM_ARB_TIMEOUT_EN
    assign rsp_err           = r_rsp_err;
`else
    assign rsp_err           = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter (N_REQ=2). Timeout checks are built
//   only when DMEM_ARB_TIMEOUT_EN is defined (DUT then uses TIMEOUT=8).
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 64;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [3:0]   req_cmd;
    logic [63:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_size;
    logic [1:0]   req_grant;
    logic [1:0]   req_ack;
    logic [63:0]  rsp_data;
    logic         rsp_err;
    logic [1:0]   proc2Dmem_command;
    logic [31:0]  proc2Dmem_addr;
    logic [63:0]  proc2Dmem_data;
    logic [1:0]   proc2Dmem_size;
    logic [3:0]   Dmem2proc_response;
    logic [63:0]  Dmem2proc_data;
    logic [3:0]   Dmem2proc_tag;

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(
        .N_REQ   (2),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_cmd            (req_cmd),
        .req_addr           (req_addr),
        .req_data           (req_data),
        .req_size           (req_size),
        .req_grant          (req_grant),
        .req_ack            (req_ack),
        .rsp_data           (rsp_data),
        .rsp_err            (rsp_err),
        .proc2Dmem_command  (proc2Dmem_command),
        .proc2Dmem_addr     (proc2Dmem_addr),
        .proc2Dmem_data     (proc2Dmem_data),
        .proc2Dmem_size     (proc2Dmem_size),
        .Dmem2proc_response (Dmem2proc_response),
        .Dmem2proc_data     (Dmem2proc_data),
        .Dmem2proc_tag      (Dmem2proc_tag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int fu, input logic [1:0] cmd, input logic [31:0] addr,
                           input logic [63:0] data, input logic [1:0] size);
        req_cmd[fu*2 +: 2]   = cmd;
        req_addr[fu*32 +: 32] = addr;
        req_data[fu*64 +: 64] = data;
        req_size[fu*2 +: 2]  = size;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_grant"}, 64'(req_grant), 64'h0);
        chk({pfx, "_ack"},   64'(req_ack), 64'h0);
        chk({pfx, "_cmd"},   64'(proc2Dmem_command), 64'h0);
        chk({pfx, "_addr"},  64'(proc2Dmem_addr), 64'h0);
        chk({pfx, "_wdata"}, proc2Dmem_data, 64'h0);
        chk({pfx, "_size"},  64'(proc2Dmem_size), 64'h0);
        chk({pfx, "_rdata"}, rsp_data, 64'h0);
        chk({pfx, "_err"},   64'(rsp_err), 64'h0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        req_valid = '0; req_cmd = '0; req_addr = '0; req_data = '0; req_size = '0;
        Dmem2proc_response = '0; Dmem2proc_data = '0; Dmem2proc_tag = '0;
        #2;
        chk_all_zero("rst");
        tick(); tick();
        reset = 1'b1;

        // Load FU0 @0x100, accepted with tag 3 in cycle 1, data in cycle 5, ack cycle 6
        set_req(0, BUS_LOAD, 32'h100, 64'h0, DOUBLE);
        req_valid = 2'b01;
        tick();                                   // cycle 1
        chk("t1_grant", 64'(req_grant), 64'h1);
        chk("t1_cmd", 64'(proc2Dmem_command), 64'(BUS_LOAD));
        chk("t1_addr", 64'(proc2Dmem_addr), 64'h100);
        Dmem2proc_response = 4'd3;
        tick();                                   // cycle 2
        Dmem2proc_response = 4'd0;
        chk("t1_wait_cmd", 64'(proc2Dmem_command), 64'(BUS_NONE));
        chk("t1_wait_grant", 64'(req_grant), 64'h1);
        tick(); tick(); tick();                   // cycle 5
        chk("t1_noack", 64'(req_ack), 64'h0);
        Dmem2proc_tag = 4'd3;
        Dmem2proc_data = 64'hDEADBEEF_CAFEF00D;
        tick();                                   // cycle 6
        Dmem2proc_tag = 4'd0;
        chk("t1_ack", 64'(req_ack), 64'h1);
        chk("t1_rdata", rsp_data, 64'hDEADBEEF_CAFEF00D);
        chk("t1_err", 64'(rsp_err), 64'h0);
        req_valid = 2'b00;
        tick();                                   // cycle 7, IDLE
        chk("t1_idle_ack", 64'(req_ack), 64'h0);
        chk("t1_idle_grant", 64'(req_grant), 64'h0);

        // Both FUs request continuously after reset: grants 0,1,0,1
        reset = 1'b0; #2; reset = 1'b1;
        set_req(0, BUS_STORE, 32'h8, 64'h11, WORD);
        set_req(1, BUS_STORE, 32'h10, 64'h22, WORD);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] eg;
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();                               // ISSUE
            chk($sformatf("t2_grant%0d", i), 64'(req_grant), 64'(eg));
            chk($sformatf("t2_issue_ack%0d", i), 64'(req_ack), 64'h0);
            chk($sformatf("t2_addr%0d", i), 64'(proc2Dmem_addr), (i % 2 == 0) ? 64'h8 : 64'h10);
            Dmem2proc_response = 4'd1;
            tick();                               // RESP
            Dmem2proc_response = 4'd0;
            chk($sformatf("t2_ack%0d", i), 64'(req_ack), 64'(eg));
            chk($sformatf("t2_resp_grant%0d", i), 64'(req_grant), 64'(eg));
            tick();                               // IDLE
            chk($sformatf("t2_idle_ack%0d", i), 64'(req_ack), 64'h0);
            chk($sformatf("t2_idle_grant%0d", i), 64'(req_grant), 64'h0);
        end
        req_valid = 2'b00;

        // Rejected three times, accepted with tag 2 on the fourth ISSUE cycle
        set_req(0, BUS_LOAD, 32'h200, 64'h0, DOUBLE);
        req_valid = 2'b01;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_cmd%0d", k), 64'(proc2Dmem_command), 64'(BUS_LOAD));
            chk($sformatf("t3_addr%0d", k), 64'(proc2Dmem_addr), 64'h200);
            chk($sformatf("t3_size%0d", k), 64'(proc2Dmem_size), 64'(DOUBLE));
            if (k == 1) set_req(0, BUS_STORE, 32'h999, 64'h5, BYTE);
            Dmem2proc_response = (k == 3) ? 4'd2 : 4'd0;
            tick();
        end
        Dmem2proc_response = 4'd0;
        chk("t3_wait_cmd", 64'(proc2Dmem_command), 64'(BUS_NONE));
        chk("t3_wait_ack", 64'(req_ack), 64'h0);
        tick();
        chk("t3_wait_cmd2", 64'(proc2Dmem_command), 64'(BUS_NONE));
        Dmem2proc_tag = 4'd2;
        Dmem2proc_data = 64'h11223344_55667788;
        req_valid = 2'b00;
        tick();
        Dmem2proc_tag = 4'd0;
        chk("t3_ack", 64'(req_ack), 64'h1);
        chk("t3_rdata", rsp_data, 64'h11223344_55667788);
        tick();

        // Store FU1 @0x40 WORD: ack the cycle after acceptance, no WAIT
        set_req(1, BUS_STORE, 32'h40, 64'hA5A50000_12345678, WORD);
        req_valid = 2'b10;
        tick();
        chk("t4_grant", 64'(req_grant), 64'h2);
        chk("t4_cmd", 64'(proc2Dmem_command), 64'(BUS_STORE));
        chk("t4_addr", 64'(proc2Dmem_addr), 64'h40);
        chk("t4_wdata", proc2Dmem_data, 64'hA5A50000_12345678);
        chk("t4_size", 64'(proc2Dmem_size), 64'(WORD));
        Dmem2proc_response = 4'd1;
        tick();
        Dmem2proc_response = 4'd0;
        chk("t4_ack", 64'(req_ack), 64'h2);
        chk("t4_err", 64'(rsp_err), 64'h0);
        chk("t4_rdata_hold", rsp_data, 64'h11223344_55667788);
        chk("t4_cmd_none", 64'(proc2Dmem_command), 64'(BUS_NONE));
        req_valid = 2'b00;
        tick();
        chk("t4_idle_ack", 64'(req_ack), 64'h0);

        // Waiting on tag 3: tag 5 ignored, tag 3 captured
        set_req(0, BUS_LOAD, 32'h300, 64'h0, DOUBLE);
        req_valid = 2'b01;
        tick();
        Dmem2proc_response = 4'd3;
        tick();
        Dmem2proc_response = 4'd0;
        Dmem2proc_tag = 4'd5;
        Dmem2proc_data = 64'h0000_0000_0000_0BAD;
        tick();
        chk("t5_tag5_ack", 64'(req_ack), 64'h0);
        chk("t5_tag5_grant", 64'(req_grant), 64'h1);
        Dmem2proc_tag = 4'd3;
        Dmem2proc_data = 64'h01234567_89ABCDEF;
        tick();
        Dmem2proc_tag = 4'd0;
        chk("t5_ack", 64'(req_ack), 64'h1);
        chk("t5_rdata", rsp_data, 64'h01234567_89ABCDEF);
        req_valid = 2'b00;
        tick();

`ifdef DMEM_ARB_TIMEOUT_EN
        // No tag ever returns: ack with error 8 cycles after entering WAIT
        set_req(0, BUS_LOAD, 32'h400, 64'h0, DOUBLE);
        req_valid = 2'b01;
        tick();
        Dmem2proc_response = 4'd4;
        tick();                                   // first WAIT cycle
        Dmem2proc_response = 4'd0;
        n = 0;
        while (req_ack == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        chk("to_latency", 64'(n), 64'd8);
        chk("to_ack", 64'(req_ack), 64'h1);
        chk("to_err", 64'(rsp_err), 64'h1);
        chk("to_rdata", rsp_data, 64'h0);
        req_valid = 2'b00;
        Dmem2proc_tag = 4'd4;
        Dmem2proc_data = 64'hFFFF_EEEE_DDDD_CCCC;
        tick();
        Dmem2proc_tag = 4'd0;
        chk("to_late_ack", 64'(req_ack), 64'h0);
        chk("to_late_rdata", rsp_data, 64'h0);
        tick();
`endif

        // Reset mid-WAIT clears outputs at once; next grant restarts at FU0
        set_req(1, BUS_LOAD, 32'h500, 64'h0, DOUBLE);
        req_valid = 2'b10;
        tick();
        chk("t6_grant", 64'(req_grant), 64'h2);
        Dmem2proc_response = 4'd7;
        tick();
        Dmem2proc_response = 4'd0;
        tick();
        chk("t6_wait_grant", 64'(req_grant), 64'h2);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        #1;
        reset = 1'b1;
        set_req(0, BUS_STORE, 32'h600, 64'h33, WORD);
        req_valid = 2'b11;
        tick();
        chk("t6_first_grant", 64'(req_grant), 64'h1);
        Dmem2proc_response = 4'd1;
        tick();
        Dmem2proc_response = 4'd0;
        chk("t6_first_ack", 64'(req_ack), 64'h1);
        req_valid = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
